// File: rtl/vga_timing_monitor_pkg.sv
// Shared 640x480@60 timing constants and monitor state encoding for the VGA
// receive-side checker.
package vga_timing_monitor_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_CW = 12;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } mon_state_t;

endpackage

// File: rtl/vga_timing_monitor_sync_edge.sv
// Falling-edge detector for an active-low sync input, evaluated only on pixel
// strobes so that the history tracks the pixel stream rather than clk_100mhz.
module vga_sync_edge (
   input  logic clk_100mhz,
   input  logic rst,
   input  logic pix_en,
   input  logic sync_in,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         prev <= 1'b1;
      end else if (pix_en) begin
         prev <= sync_in;
      end
   end

   assign fall = pix_en && prev && !sync_in;

endmodule

// File: rtl/vga_timing_monitor.sv
// Measures line length and frame height of the VGA stream, flags deviations
// from nominal timing and captures the pixel at one active-region coordinate.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_ACQUIRE | waiting for the first vsync fall; no errors reported
//   ST_MEASURE | measuring full frames; a clean frame moves to ST_LOCKED
//   ST_LOCKED  | timing matches; any line/frame error drops to ST_MEASURE
module vga_timing_monitor
   import vga_timing_monitor_pkg::*;
#(
   parameter int H_TOTAL  = VGA_H_TOTAL,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int V_TOTAL  = VGA_V_TOTAL,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int CW       = VGA_CW
) (
   input  logic          clk_100mhz,
   input  logic          rst,
   input  logic          pix_en,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          blank,
   input  logic [7:0]    pixel_r,
   input  logic [7:0]    pixel_g,
   input  logic [7:0]    pixel_b,
   input  logic [CW-1:0] cap_x,
   input  logic [CW-1:0] cap_y,
   output logic [23:0]   cap_pixel,
   output logic          cap_valid,
   output logic [CW-1:0] line_len,
   output logic [CW-1:0] frame_lines,
   output logic          locked,
   output logic          err_h,
   output logic          err_v,
   output logic [7:0]    err_count
);

   localparam int            CW1        = CW + 1;
   localparam logic [CW:0]   ONE        = CW1'(1);
   localparam logic [CW:0]   H_TOTAL_C  = CW1'(H_TOTAL);
   localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
   localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      logic [CW:0] s;
      s = {1'b0, v} + ONE;
      return s[CW] ? {CW{1'b1}} : s[CW-1:0];
   endfunction

   mon_state_t    state;
   logic          hs_fall, vs_fall;
   logic [CW-1:0] h_cnt, act_x, v_cnt, act_y;
   logic [CW-1:0] h_len, v_end, y_end;
   logic [CW:0]   h_plus;
   logic          line_act, frame_err;
   logic          line_bad, frame_bad_v, frame_bad, cap_hit;

   vga_sync_edge u_hs_edge (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .pix_en     (pix_en),
      .sync_in    (hsync),
      .fall       (hs_fall)
   );

   vga_sync_edge u_vs_edge (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .pix_en     (pix_en),
      .sync_in    (vsync),
      .fall       (vs_fall)
   );

   // A vsync fall coincident with an hsync fall closes that line first.
   always_comb begin
      h_plus      = {1'b0, h_cnt} + ONE;
      h_len       = h_plus[CW] ? {CW{1'b1}} : h_plus[CW-1:0];
      line_bad    = (state != ST_ACQUIRE) &&
                    ((h_plus != H_TOTAL_C) || (line_act && (act_x != H_ACTIVE_C)));
      v_end       = hs_fall ? sat_inc(v_cnt) : v_cnt;
      y_end       = (hs_fall && line_act) ? sat_inc(act_y) : act_y;
      frame_bad_v = (state != ST_ACQUIRE) &&
                    ((v_end != V_TOTAL_C) || (y_end != V_ACTIVE_C));
      frame_bad   = frame_err || (hs_fall && line_bad) || frame_bad_v;
      cap_hit     = pix_en && !blank && (act_x == cap_x) && (act_y == cap_y);
   end

   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         h_cnt       <= '0;
         act_x       <= '0;
         v_cnt       <= '0;
         act_y       <= '0;
         line_act    <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         cap_pixel   <= '0;
         cap_valid   <= 1'b0;
         err_h       <= 1'b0;
         err_v       <= 1'b0;
      end else begin
         cap_valid <= 1'b0;
         err_h     <= 1'b0;
         err_v     <= 1'b0;
         if (pix_en) begin
            if (cap_hit) begin
               cap_pixel <= {pixel_r, pixel_g, pixel_b};
               cap_valid <= 1'b1;
            end
            if (hs_fall) begin
               line_len <= h_len;
               h_cnt    <= '0;
               act_x    <= '0;
               line_act <= 1'b0;
               v_cnt    <= v_end;
               act_y    <= y_end;
               err_h    <= line_bad;
            end else begin
               h_cnt <= h_len;
               if (!blank) begin
                  act_x    <= sat_inc(act_x);
                  line_act <= 1'b1;
               end
            end
            if (vs_fall) begin
               frame_lines <= v_end;
               v_cnt       <= '0;
               act_y       <= '0;
               err_v       <= frame_bad_v;
            end
         end
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         state     <= ST_ACQUIRE;
         locked    <= 1'b0;
         err_count <= '0;
         frame_err <= 1'b0;
      end else if (pix_en) begin
         if (vs_fall) begin
            frame_err <= 1'b0;
            case (state)
               ST_ACQUIRE: begin
                  state  <= ST_MEASURE;
                  locked <= 1'b0;
               end
               ST_MEASURE: begin
                  if (frame_bad) begin
                     err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                  end else begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (frame_bad) begin
                     state     <= ST_MEASURE;
                     locked    <= 1'b0;
                     err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                  end
               end
               default: begin
                  state  <= ST_ACQUIRE;
                  locked <= 1'b0;
               end
            endcase
         end else if (hs_fall && line_bad) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized-gap VGA stream against a frame-level reference model of the
// timing monitor, using a reduced raster so whole frames stay short.
module tb_vga_timing_monitor;

   localparam int HT = 24;
   localparam int HA = 16;
   localparam int HB = 4;
   localparam int VT = 12;
   localparam int VA = 8;
   localparam int VB = 2;
   localparam int CW = 12;
   localparam int SAT = 4095;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pix_en = 1'b0;
   logic          hsync = 1'b1;
   logic          vsync = 1'b1;
   logic          blank = 1'b1;
   logic [7:0]    pr = 8'h00, pg = 8'h00, pb = 8'h00;
   logic [CW-1:0] cap_x = '0, cap_y = '0;
   logic [23:0]   cap_pixel;
   logic          cap_valid;
   logic [CW-1:0] line_len, frame_lines;
   logic          locked, err_h, err_v;
   logic [7:0]    err_count;

   int total = 0;
   int bad = 0;
   int n_eh = 0, n_ev = 0, n_cv = 0;
   int base_eh = 0, base_ev = 0, base_cv = 0;

   // frame-level model state and the record of the frame being generated
   int          m_state = 0;
   int          m_errc = 0;
   int          g_lines = 0, g_act = 0, g_bad = 0, g_last_len = 0, g_hits = 0;
   logic [23:0] g_pix = '0;
   bit          fixed_b = 1'b0;

   always #5 clk = ~clk;

   vga_timing_monitor #(
      .H_TOTAL  (HT),
      .H_ACTIVE (HA),
      .V_TOTAL  (VT),
      .V_ACTIVE (VA),
      .CW       (CW)
   ) dut (
      .clk_100mhz  (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .pixel_r     (pr),
      .pixel_g     (pg),
      .pixel_b     (pb),
      .cap_x       (cap_x),
      .cap_y       (cap_y),
      .cap_pixel   (cap_pixel),
      .cap_valid   (cap_valid),
      .line_len    (line_len),
      .frame_lines (frame_lines),
      .locked      (locked),
      .err_h       (err_h),
      .err_v       (err_v),
      .err_count   (err_count)
   );

   always @(negedge clk) begin
      if (err_h === 1'b1) n_eh++;
      if (err_v === 1'b1) n_ev++;
      if (cap_valid === 1'b1) n_cv++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cap_pixel"}, 32'(cap_pixel), 0);
      chk({tag, "_line_len"}, 32'(line_len), 0);
      chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
      chk({tag, "_flags"}, 32'({cap_valid, locked, err_h, err_v}), 0);
      chk({tag, "_err_count"}, 32'(err_count), 0);
   endtask

   // garbage on the video inputs while pix_en is low must be ignored
   task automatic put_sample(input logic hs, input logic vs, input logic bl,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      repeat ($urandom_range(0, 1)) begin
         pix_en = 1'b0;
         hsync  = 1'($urandom);
         vsync  = 1'($urandom);
         blank  = 1'($urandom);
         pr     = 8'($urandom);
         @(posedge clk);
         #1;
      end
      hsync  = hs;
      vsync  = vs;
      blank  = bl;
      pr     = r;
      pg     = g;
      pb     = b;
      pix_en = 1'b1;
      @(posedge clk);
      #1;
      pix_en = 1'b0;
   endtask

   // Called right after the vsync-fall sample that closes the recorded frame.
   task automatic close_window();
      int exp_fl, exp_ll, exp_eh, exp_ev, exp_hits;
      bit bad_v;
      @(negedge clk);
      #1;
      if (m_state == 0) begin
         exp_fl   = 1;
         exp_ll   = 1;
         exp_eh   = 0;
         exp_ev   = 0;
         exp_hits = 0;
         m_state  = 1;
      end else begin
         bad_v    = (g_lines != VT) || (g_act != VA);
         exp_eh   = g_bad;
         exp_ev   = bad_v ? 1 : 0;
         exp_fl   = (g_lines > SAT) ? SAT : g_lines;
         exp_ll   = (g_last_len > SAT) ? SAT : g_last_len;
         exp_hits = g_hits;
         if (bad_v || g_bad > 0) begin
            if (m_errc < 255) m_errc++;
            m_state = 1;
         end else begin
            m_state = 2;
         end
      end
      chk("frame_lines", 32'(frame_lines), exp_fl);
      chk("line_len", 32'(line_len), exp_ll);
      chk("err_h_pulses", n_eh - base_eh, exp_eh);
      chk("err_v_pulses", n_ev - base_ev, exp_ev);
      chk("locked", 32'(locked), (m_state == 2) ? 1 : 0);
      chk("err_count", 32'(err_count), m_errc);
      chk("cap_pulses", n_cv - base_cv, exp_hits);
      if (exp_hits > 0) chk("cap_pixel", 32'(cap_pixel), 32'(g_pix));
      base_eh = n_eh;
      base_ev = n_ev;
      base_cv = n_cv;
   endtask

   task automatic send_line(input int len, input int y);
      for (int h = 0; h < len; h++) begin
         logic       act;
         int         x, ya;
         logic [7:0] b;
         act = (y >= VB) && (y < VB + VA) && (h >= HB) && (h < HB + HA);
         x   = h - HB;
         ya  = y - VB;
         b   = fixed_b ? 8'hA5 : 8'($urandom);
         if (act && x == int'(cap_x) && ya == int'(cap_y)) begin
            g_hits++;
            g_pix = {x[7:0], ya[7:0], b};
         end
         put_sample(!(h < HB), !(y < VB), !act, x[7:0], ya[7:0], b);
         if (h == 0 && y == 0) begin
            close_window();
            g_lines = 0;
            g_act   = 0;
            g_bad   = 0;
            g_hits  = 0;
         end
      end
      g_lines++;
      if (len != HT) g_bad++;
      g_last_len = len;
      if (y >= VB && y < VB + VA) g_act++;
   endtask

   task automatic send_frame(input int n, input int bad_line, input int bad_len);
      for (int y = 0; y < n; y++) begin
         send_line((y == bad_line) ? bad_len : HT, y);
      end
   endtask

   task automatic rand_cap();
      cap_x = CW'($urandom_range(0, HA - 1));
      cap_y = CW'($urandom_range(0, VA - 1));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset");
      base_eh = n_eh;
      base_ev = n_ev;
      base_cv = n_cv;
      rst = 1'b1;

      // nominal frames: lock after the second vsync fall
      for (int i = 0; i < 3; i++) begin
         rand_cap();
         send_frame(VT, -1, 0);
      end

      // directed capture coordinate with a fixed blue channel
      fixed_b = 1'b1;
      cap_x   = CW'(10);
      cap_y   = CW'(5);
      send_frame(VT, -1, 0);
      chk("cap_directed", 32'(cap_pixel), 32'h000A05A5);
      fixed_b = 1'b0;

      // one long line while locked, then recovery
      rand_cap();
      send_frame(VT, 3, HT + 1);
      send_frame(VT, -1, 0);
      send_frame(VT, -1, 0);

      // short frame, then recovery
      send_frame(VT - 1, -1, 0);
      send_frame(VT, -1, 0);
      send_frame(VT, -1, 0);

      // missing hsync long enough to saturate the line counter
      send_frame(VT, VT - 1, 5000);
      send_frame(VT, -1, 0);
      send_frame(VT, -1, 0);

      // asynchronous reset in the middle of a locked frame
      send_frame(5, -1, 0);
      chk("locked_before_reset", 32'(locked), 1);
      rst = 1'b0;
      #1;
      chk_zero("mid_reset");
      base_eh = n_eh;
      base_ev = n_ev;
      base_cv = n_cv;
      m_state = 0;
      m_errc  = 0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      send_frame(VT, -1, 0);
      send_frame(VT, -1, 0);
      send_frame(VT, -1, 0);

      // long run of bad frames saturates the error counter
      for (int i = 0; i < 300; i++) begin
         send_frame(3, -1, 0);
      end
      send_frame(VT, -1, 0);
      chk("err_count_saturated", 32'(err_count), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
